// File: rtl/pair_pkg.sv
// rtl/pair_pkg.sv - shared constants for the pair-map preimage scanner
package pair_pkg;

    localparam int PAIR_W = 2;
    localparam int CNT_W  = 5;
    localparam logic [3:0] IDX_LAST = 4'd15;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t SCAN = 2'd1;
    localparam state_t EMIT = 2'd2;
    localparam state_t DONE = 2'd3;

endpackage

// File: rtl/pair_map.sv
// rtl/pair_map.sv - combinational 2-bit pair map c = F(a, b)
import pair_pkg::*;

module pair_map (
    input  logic [PAIR_W-1:0] a,
    input  logic [PAIR_W-1:0] b,
    output logic [PAIR_W-1:0] c
);

    logic p, q, r, s;

    assign p = a[1];
    assign q = a[0];
    assign r = b[1];
    assign s = b[0];

    assign c[1] = (~p & r & s) | (~p & q & r) | (p & ~r);
    assign c[0] = (p | q | s) & (q | r) & (~p | r);

endmodule

// File: rtl/pair_preimage_scan.sv
// rtl/pair_preimage_scan.sv - walks all (a, b) pairs and streams those mapping to target
import pair_pkg::*;

module pair_preimage_scan (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PAIR_W-1:0] target,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PAIR_W-1:0] out_a,
    output logic [PAIR_W-1:0] out_b,
    output logic              done,
    output logic [CNT_W-1:0]  match_count
);

    state_t            state;
    state_t            state_next;
    logic [3:0]        idx;
    logic [PAIR_W-1:0] tgt;
    logic [PAIR_W-1:0] map_c;
    logic              hit;
    logic              last;

    pair_map u_pair_map (
        .a (idx[3:2]),
        .b (idx[1:0]),
        .c (map_c)
    );

    assign hit  = (map_c == tgt);
    assign last = (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SCAN;
            SCAN: begin
                if (hit)       state_next = EMIT;
                else if (last) state_next = DONE;
            end
            EMIT: begin
                if (out_valid && out_ready) state_next = last ? DONE : SCAN;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status flags are pure decodes of the state register, so they carry no input path.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= 4'd0;
            tgt         <= '0;
            match_count <= '0;
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx         <= 4'd0;
                        tgt         <= target;
                        match_count <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        out_a     <= idx[3:2];
                        out_b     <= idx[1:0];
                        out_valid <= 1'b1;
                    end else if (!last) begin
                        idx <= idx + 4'd1;
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        out_valid   <= 1'b0;
                        match_count <= match_count + CNT_W'(1);
                        if (!last) idx <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pair_preimage_scan.md
# pair_preimage_scan

Sequential inverse of the lab's 2-bit pair map `c = F(a, b)`. Given a 2-bit target, the block walks all 16 `(a, b)` operand pairs in ascending order. It emits every pair with `F(a, b) == target` over a valid/ready stream, then reports the match count. The block sits beside the combinational pair-map logic and serves as its exhaustive reverse lookup for lab self-checking.

## Interface
- Parameters: none. All widths are fixed by the 2-bit pair map.
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `start` input 1 — begin a scan. Sampled only in IDLE.
- `target` input 2 — `c` value to invert. Latched on the accepted `start`.
- `busy` output 1 — high from the accepted `start` through the DONE cycle.
- `out_valid` output 1 — `out_a`/`out_b` hold a matching pair.
- `out_ready` input 1 — consumer accepts the pair when high together with `out_valid`.
- `out_a` output 2 — matching `a` operand.
- `out_b` output 2 — matching `b` operand.
- `done` output 1 — one-cycle pulse at the end of a scan.
- `match_count` output 5 — number of pairs emitted in the current or last scan. Valid when `done` is high; holds until the next accepted `start`.

## Operation
- Pair map, with `p=a[1]`, `q=a[0]`, `r=b[1]`, `s=b[0]`:
  - `c[1] = p'rs + p'qr + pr'`
  - `c[0] = (p+q+s)(q+r)(p'+r)`
- Preimages, listed by index `{a,b}`:
  - `c=00`: 0, 1, 2
  - `c=01`: 4, 5, 10, 11, 14, 15
  - `c=10`: 8, 9, 12, 13
  - `c=11`: 3, 6, 7
- Internal 4-bit index `idx = {a,b}` scans from 0 to 15. The latched target is held in `tgt`.
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - On `start` → SCAN.
  - Actions: `idx<=0`, `tgt<=target`, `match_count<=0`, `busy<=1`.
- SCAN, one candidate per clock:
  - If `F(idx)==tgt`: load `out_a<=idx[3:2]`, `out_b<=idx[1:0]`, set `out_valid<=1`, go to EMIT.
  - Else if `idx==15` → DONE.
  - Else `idx<=idx+1`.
- EMIT:
  - Hold `out_valid`, `out_a` and `out_b` stable until `out_valid && out_ready` at a clock edge.
  - On that handshake: `out_valid<=0`, `match_count<=match_count+1`.
  - Then go to DONE if `idx==15`; otherwise `idx<=idx+1` and return to SCAN.
- DONE:
  - `done=1` for exactly one cycle, with `busy` still high.
  - Next state is IDLE with `busy<=0`.
- `start` is ignored in SCAN, EMIT and DONE. `target` changes after acceptance have no effect.
- Index wrap: `idx` never increments past 15. Reaching 15 always terminates the scan.
- `match_count` never exceeds 6. The 5-bit width is fixed for a uniform register interface.

## Timing
- Reset, asynchronous: state=IDLE; `busy`, `out_valid` and `done` = 0; `out_a`, `out_b` and `match_count` = 0; `idx`/`tgt` = 0.
- Reset mid-scan, including during EMIT with `out_valid` high, takes effect immediately. No partial `done` follows.
- All outputs are registered. No combinational path runs from `out_ready` or `start` to any output.
- The first candidate is evaluated on the edge after the one that accepts `start`.
- With `out_ready` tied high and M matches:
  - `done` is high in the cycle after the (16+M)th edge following the start edge.
  - `busy` drops one cycle later.
- Backpressure adds one cycle of latency per stalled cycle. No pair is lost or duplicated.
- A new `start` is accepted at the earliest on the first IDLE cycle after DONE.

## Structure
- Package `pair_pkg`:
  - FSM state encoding as localparams: IDLE=0, SCAN=1, EMIT=2, DONE=3.
  - `PAIR_W=2`, `IDX_LAST=4'd15`, `CNT_W=5`.
- Sub-module `pair_map`: purely combinational, inputs `a[1:0]`, `b[1:0]`, output `c[1:0]`, implementing the equations above. It is instantiated once, fed by `idx`.
- Top: FSM, `idx`/`tgt`/`match_count` registers and output registers.

## Test plan
- `target=00`, `out_ready=1`:
  - Stream `(a,b)` = (0,0), (0,1), (0,2).
  - `match_count=3`; `done` at edge 19 after start.
- `target=01`, `out_ready=1`:
  - Stream (1,0), (1,1), (2,2), (2,3), (3,2), (3,3) in order.
  - `match_count=6`.
- `target=10`, `out_ready` held low 5 cycles on the first pair:
  - (2,0) is held stable with `out_valid=1` throughout the stall.
  - Full stream (2,0), (2,1), (3,0), (3,1); `match_count=4`; `done` delayed by 5 cycles.
- `target=11` with `start` re-pulsed and `target` changed to 00 mid-scan:
  - Output is still (0,3), (1,2), (1,3); `match_count=3`.
  - A `start` during the DONE cycle is ignored.
- `rst` pulsed while in EMIT on the second pair of `target=01`:
  - All outputs are 0 immediately; no `done`.
  - A subsequent `start` with `target=01` yields the full 6-pair stream.
